debounce_edge_detector: RTL and testbench
=========================================

# debounce_edge_detector

Conditions one raw, asynchronous, bouncing level input (push button) into a clean, clock-synchronous level. It also emits single-cycle pulses on each clean rising and falling transition. It sits between a board pin and handshake logic, which latches a request on the `neg_edge` pulse (button press on an active-low button).

## Interface
Parameters:
- `CYCLES`, default 255: number of consecutive clock cycles the synchronized input must differ from the clean level before the clean level changes; legal range ≥ 1.

Ports:
- `clk`  in  1  single system clock, all logic on rising edge.
- `reset_low`  in  1  reset, asynchronous, active-low.
- `bit_in`  in  1  raw button level, asynchronous to `clk`, idle high.
- `bit_out`  out  1  debounced level.
- `pos_edge`  out  1  one-cycle pulse when `bit_out` goes 0→1.
- `neg_edge`  out  1  one-cycle pulse when `bit_out` goes 1→0.

## Operation
- Synchronizer: two flops `s1 <= bit_in`, `s2 <= s1`. Both reset to 1.
- Debounce counter: width `$clog2(CYCLES+1)`, reset to 0.
  - If `s2 == bit_out`, the counter clears to 0.
  - Else, if the counter equals `CYCLES-1`, then `bit_out <= s2` and the counter clears.
  - Else the counter increments.
- A single agreeing cycle during the count, such as a bounce back, restarts the count from 0. No partial credit.
- `bit_out` reset value: 1.
- Edge detector:
  - Register `prev <= bit_out`, reset 1.
  - `pos_edge <= bit_out & ~prev`; `neg_edge <= prev & ~bit_out`.
  - Both outputs are registered and reset to 0.
- `pos_edge` and `neg_edge` are never high simultaneously. Each is high for exactly one cycle per `bit_out` transition.
- The counter never exceeds `CYCLES-1`; no wrap-around is possible.

## Timing
- Let `bit_in` change just before rising edge 0 and then stay stable.
  - `s2` reflects it after edge 1.
  - Disagreement is counted at edges 2 … CYCLES+1.
  - `bit_out` changes at edge CYCLES+1.
  - The edge pulse is high from edge CYCLES+2 to edge CYCLES+3.
- Total latency, input change to edge pulse: CYCLES+2 rising edges.
- `CYCLES = 1`: `bit_out` follows `s2` one edge after the first disagreement.
- A pulse on `bit_in` shorter than CYCLES cycles, after synchronization, produces no `bit_out` change and no edge pulse.
- Asynchronous reset mid-count:
  - All state returns immediately to reset values: `bit_out`=1, edges 0, counter 0.
  - No edge pulse is generated by the reset itself.
  - After release, if `bit_in` is low, a normal full debounce runs and then `neg_edge` pulses.
- Reset release is assumed synchronized externally. All flops use the same asynchronous clear/preset.

## Structure
- Two sub-modules, instantiated in this top:
  - `debouncer`: synchronizer plus counter, parameter `CYCLES`, ports `clk`, `reset_low`, `bit_in`, `bit_out`.
  - `edge_detector`: ports `clk`, `reset_low`, `level`, `pos_edge`, `neg_edge`.
- Shared constants `YES = 1'b1` and `NO = 1'b0` come from the codebase common include/package. No local redefinition.
- No typedefs required.

## Test plan
- Reset held low, then released with `bit_in`=1: `bit_out`=1, `pos_edge`=0 and `neg_edge`=0 throughout 20 cycles.
- `CYCLES=4`, `bit_in` 1→0 held: `bit_out` falls at edge 5, `neg_edge` high for exactly 1 cycle at edge 6, `pos_edge` stays 0.
- `CYCLES=4`, bounce `bit_in` low for 3 cycles, high 1, low 3, then high: `bit_out` stays 1, no pulses.
- `CYCLES=4`, press then release, each held 10 cycles: one `neg_edge` pulse, then one `pos_edge` pulse 10 cycles later; `bit_out` tracks with latency 5.
- `CYCLES=4`, `bit_in` low, `reset_low` asserted at counter=2: `bit_out`=1 and counter=0 immediately. After release with input still low, `neg_edge` at edge 6 after release.
- Default `CYCLES=255`, low held 254 synchronized cycles then high: no change. Low held ≥255 cycles: `neg_edge` pulses once at latency 257 edges.

Source files
------------

// File: rtl/debounce_edge_detector_pkg.sv
// -----------------------------------------------------------------------------
// debounce_edge_detector_pkg
//   Shared constants for the button-conditioning slice.
//   YES / NO : single-bit logic levels used for reset values and comparisons.
// -----------------------------------------------------------------------------
package debounce_edge_detector_pkg;

   localparam logic YES = 1'b1;
   localparam logic NO  = 1'b0;

endpackage : debounce_edge_detector_pkg

// File: rtl/debounce_edge_detector_debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//   Two-flop synchronizer followed by a consecutive-disagreement counter.
//   The clean level only moves after the synchronized input has disagreed
//   with it for CYCLES back-to-back clocks; one agreeing cycle restarts the
//   count from zero.
//
// Ports
//   clk       in   system clock, rising edge
//   reset_low in   asynchronous active-low reset
//   bit_in    in   raw button level, asynchronous to clk, idle high
//   bit_out   out  debounced level, resets high
// -----------------------------------------------------------------------------
module debouncer
   import debounce_edge_detector_pkg::*;
#(
   parameter int CYCLES = 255
) (
   input  logic clk,
   input  logic reset_low,
   input  logic bit_in,
   output logic bit_out
);

   localparam int                CNT_W = $clog2(CYCLES + 1);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CYCLES - 1);
   localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

   logic             r_s1;
   logic             r_s2;
   logic             r_level;
   logic [CNT_W-1:0] r_count;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours; blocking here would collapse the
   // two synchronizer stages into one.
   always_ff @(posedge clk or negedge reset_low) begin
      if (!reset_low) begin
         r_s1    <= YES;
         r_s2    <= YES;
         r_level <= YES;
         r_count <= '0;
      end else begin
         r_s1 <= bit_in;
         r_s2 <= r_s1;
         if (r_s2 == r_level) begin
            // Agreement (including a bounce back) discards any partial count.
            r_count <= '0;
         end else if (r_count == LAST) begin
            // CYCLES-th consecutive disagreement: accept the new level.
            r_level <= r_s2;
            r_count <= '0;
         end else begin
            r_count <= r_count + ONE;
         end
      end
   end

   assign bit_out = r_level;

endmodule : debouncer

// File: rtl/debounce_edge_detector_edge_detector.sv
// -----------------------------------------------------------------------------
// edge_detector
//   Registered one-cycle pulses on each transition of a clean level.
//   The history flop resets high to match the debouncer's idle level, so
//   reset never manufactures an edge.
//
// Ports
//   clk       in   system clock, rising edge
//   reset_low in   asynchronous active-low reset
//   level     in   clean, clock-synchronous level
//   pos_edge  out  one-cycle pulse after level goes 0->1
//   neg_edge  out  one-cycle pulse after level goes 1->0
// -----------------------------------------------------------------------------
module edge_detector
   import debounce_edge_detector_pkg::*;
(
   input  logic clk,
   input  logic reset_low,
   input  logic level,
   output logic pos_edge,
   output logic neg_edge
);

   logic r_prev;
   logic r_pos;
   logic r_neg;

   always_ff @(posedge clk or negedge reset_low) begin
      if (!reset_low) begin
         r_prev <= YES;
         r_pos  <= NO;
         r_neg  <= NO;
      end else begin
         r_prev <= level;
         r_pos  <= level & ~r_prev;
         r_neg  <= r_prev & ~level;
      end
   end

   assign pos_edge = r_pos;
   assign neg_edge = r_neg;

endmodule : edge_detector

// File: rtl/debounce_edge_detector.sv
// -----------------------------------------------------------------------------
// debounce_edge_detector
//   Conditions a bouncing, asynchronous push-button level into a clean
//   synchronous level plus single-cycle rising / falling pulses.
//   Input change to edge pulse latency is CYCLES+2 rising edges.
//
// Ports
//   clk       in   system clock, rising edge
//   reset_low in   asynchronous active-low reset
//   bit_in    in   raw button level, idle high
//   bit_out   out  debounced level
//   pos_edge  out  one-cycle pulse when bit_out goes 0->1
//   neg_edge  out  one-cycle pulse when bit_out goes 1->0 (button press)
// -----------------------------------------------------------------------------
module debounce_edge_detector
   import debounce_edge_detector_pkg::*;
#(
   parameter int CYCLES = 255
) (
   input  logic clk,
   input  logic reset_low,
   input  logic bit_in,
   output logic bit_out,
   output logic pos_edge,
   output logic neg_edge
);

   logic w_level;

   debouncer #(
      .CYCLES (CYCLES)
   ) u_debouncer (
      .clk       (clk),
      .reset_low (reset_low),
      .bit_in    (bit_in),
      .bit_out   (w_level)
   );

   edge_detector u_edge_detector (
      .clk       (clk),
      .reset_low (reset_low),
      .level     (w_level),
      .pos_edge  (pos_edge),
      .neg_edge  (neg_edge)
   );

   assign bit_out = w_level;

endmodule : debounce_edge_detector

// File: tb/tb_debounce_edge_detector.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge_detector
//   Three instances (CYCLES = 4, 1, 255) share clock and reset. Stimulus
//   pushes the expected output events (level change / pulse, with the cycle
//   on which each must be observed) into a scoreboard queue; a monitor per
//   instance samples on the falling clock edge and matches every observed
//   event against the queue.
//   Timing model: an input driven just after posedge n reaches bit_out at
//   posedge n+CYCLES+2 and the edge pulse at posedge n+CYCLES+3.
// -----------------------------------------------------------------------------
module tb_debounce_edge_detector;

   localparam int K_FALL = 0;
   localparam int K_RISE = 1;
   localparam int K_NEG  = 2;
   localparam int K_POS  = 3;

   typedef struct {
      int dut;
      int kind;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic reset_low = 1'b0;
   logic b4 = 1'b1, b1 = 1'b1, b255 = 1'b1;
   logic out4, pe4, ne4;
   logic out1, pe1, ne1;
   logic out255, pe255, ne255;
   logic last4 = 1'b1, last1 = 1'b1, last255 = 1'b1;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   ev_t  sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   debounce_edge_detector #(.CYCLES(4)) dut4 (
      .clk(clk), .reset_low(reset_low), .bit_in(b4),
      .bit_out(out4), .pos_edge(pe4), .neg_edge(ne4));

   debounce_edge_detector #(.CYCLES(1)) dut1 (
      .clk(clk), .reset_low(reset_low), .bit_in(b1),
      .bit_out(out1), .pos_edge(pe1), .neg_edge(ne1));

   debounce_edge_detector dut255 (
      .clk(clk), .reset_low(reset_low), .bit_in(b255),
      .bit_out(out255), .pos_edge(pe255), .neg_edge(ne255));

   task automatic check(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic push(input int dut, input int kind, input int at);
      ev_t e;
      e.dut  = dut;
      e.kind = kind;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   // Level change at n+C+2, pulse at n+C+3 for an input driven after posedge n.
   task automatic expect_change(input int dut, input int c, input int n, input logic to);
      push(dut, to ? K_RISE : K_FALL, n + c + 2);
      push(dut, to ? K_POS  : K_NEG,  n + c + 3);
   endtask

   task automatic observe(input int dut, input int kind);
      int idx = -1;
      for (int i = 0; i < sb.size(); i++)
         if (idx < 0 && sb[i].dut == dut) idx = i;
      if (idx < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL dut%0d_unexpected_event: got kind %0d at cycle %0d, expected none",
                  dut, kind, cyc);
      end else begin
         check($sformatf("dut%0d_event_kind", dut), kind, sb[idx].kind);
         check($sformatf("dut%0d_event_cycle", dut), cyc, sb[idx].cyc);
         sb.delete(idx);
      end
   endtask

   always @(negedge clk) begin
      if (out4 !== last4) observe(4, out4 ? K_RISE : K_FALL);
      if (pe4) observe(4, K_POS);
      if (ne4) observe(4, K_NEG);
      last4 <= out4;
   end

   always @(negedge clk) begin
      if (out1 !== last1) observe(1, out1 ? K_RISE : K_FALL);
      if (pe1) observe(1, K_POS);
      if (ne1) observe(1, K_NEG);
      last1 <= out1;
   end

   always @(negedge clk) begin
      if (out255 !== last255) observe(255, out255 ? K_RISE : K_FALL);
      if (pe255) observe(255, K_POS);
      if (ne255) observe(255, K_NEG);
      last255 <= out255;
   end

   task automatic wait_cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;

      // Reset held: all outputs at reset values.
      wait_cyc(3);
      check("rst_out4", out4, 1);     check("rst_pos4", pe4, 0);     check("rst_neg4", ne4, 0);
      check("rst_out1", out1, 1);     check("rst_pos1", pe1, 0);     check("rst_neg1", ne1, 0);
      check("rst_out255", out255, 1); check("rst_pos255", pe255, 0); check("rst_neg255", ne255, 0);
      reset_low = 1'b1;

      // Idle high for 20 cycles: no events (monitor flags any), level stays 1.
      wait_cyc(20);
      check("idle_out4", out4, 1);
      check("idle_out1", out1, 1);
      check("idle_out255", out255, 1);

      // CYCLES=4: press 10 cycles then release.
      n = cyc;
      b4 = 1'b0;
      expect_change(4, 4, n, 1'b0);
      wait_cyc(10);
      check("press_out4", out4, 0);
      n = cyc;
      b4 = 1'b1;
      expect_change(4, 4, n, 1'b1);
      wait_cyc(12);
      check("release_out4", out4, 1);

      // CYCLES=4: bounce 3 low / 1 high / 3 low: never reaches 4 in a row.
      b4 = 1'b0; wait_cyc(3);
      b4 = 1'b1; wait_cyc(1);
      b4 = 1'b0; wait_cyc(3);
      b4 = 1'b1; wait_cyc(12);
      check("bounce_out4", out4, 1);

      // CYCLES=4: reset asserted with counter at 2, input held low throughout.
      n = cyc;
      b4 = 1'b0;
      wait_cyc(4);
      check("midcount_cnt4", int'(dut4.u_debouncer.r_count), 2);
      reset_low = 1'b0;
      #1;
      check("midrst_cnt4", int'(dut4.u_debouncer.r_count), 0);
      check("midrst_out4", out4, 1);
      check("midrst_neg4", ne4, 0);
      wait_cyc(2);
      n = cyc;
      reset_low = 1'b1;
      expect_change(4, 4, n, 1'b0);
      wait_cyc(12);
      n = cyc;
      b4 = 1'b1;
      expect_change(4, 4, n, 1'b1);
      wait_cyc(12);

      // CYCLES=1: level follows one edge after the first disagreement.
      n = cyc;
      b1 = 1'b0;
      expect_change(1, 1, n, 1'b0);
      wait_cyc(6);
      check("press_out1", out1, 0);
      n = cyc;
      b1 = 1'b1;
      expect_change(1, 1, n, 1'b1);
      wait_cyc(8);

      // Default CYCLES=255: 254 low cycles is one short, no change.
      b255 = 1'b0;
      wait_cyc(254);
      b255 = 1'b1;
      wait_cyc(270);
      check("short_out255", out255, 1);

      // 265 low cycles: falls, then release rises.
      n = cyc;
      b255 = 1'b0;
      expect_change(255, 255, n, 1'b0);
      wait_cyc(265);
      check("press_out255", out255, 0);
      n = cyc;
      b255 = 1'b1;
      expect_change(255, 255, n, 1'b1);
      wait_cyc(265);
      check("release_out255", out255, 1);

      // Every expected event must have been observed.
      for (int i = 0; i < sb.size(); i++)
         $display("FAIL missing_event: dut%0d kind %0d expected at cycle %0d, got none",
                  sb[i].dut, sb[i].kind, sb[i].cyc);
      check("events_pending", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_debounce_edge_detector
